// File: rtl/segre_mem_stage_sb.sv
// MEM stage with a store buffer, store-to-load forwarding, fence drain and misalignment detection.
// Loads and buffered stores share a valid/gnt/rvalid data-memory port; results feed the MEM/WB register.
module segre_mem_stage_sb #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned REG_SIZE  = 5,
   parameter int unsigned SB_DEPTH  = 4
) (
   input  logic                      clk_i,
   input  logic                      rsn_i,
   input  logic                      ex_valid_i,
   input  logic [WORD_SIZE-1:0]      alu_res_i,
   input  logic [WORD_SIZE-1:0]      rf_st_data_i,
   input  logic [1:0]                memop_type_i,
   input  logic                      memop_sign_ext_i,
   input  logic                      memop_rd_i,
   input  logic                      memop_wr_i,
   input  logic                      fence_i,
   input  logic                      rf_we_i,
   input  logic [REG_SIZE-1:0]       rf_waddr_i,
   input  logic                      tkbr_i,
   input  logic [WORD_SIZE-1:0]      new_pc_i,
   output logic                      stall_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [WORD_SIZE-1:0]      mem_addr_o,
   output logic [WORD_SIZE-1:0]      mem_wdata_o,
   output logic [WORD_SIZE/8-1:0]    mem_be_o,
   input  logic                      mem_gnt_i,
   input  logic                      mem_rvalid_i,
   input  logic [WORD_SIZE-1:0]      mem_rdata_i,
   output logic                      wb_valid_o,
   output logic [WORD_SIZE-1:0]      op_res_o,
   output logic                      rf_we_o,
   output logic [REG_SIZE-1:0]       rf_waddr_o,
   output logic                      tkbr_o,
   output logic [WORD_SIZE-1:0]      new_pc_o,
   output logic                      misaligned_o,
   output logic                      sb_empty_o
);

   localparam int unsigned BYTES = WORD_SIZE / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned WA_W  = WORD_SIZE - OFF_W;
   localparam int unsigned PTR_W = $clog2(SB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LD_REQ  = 2'd1;
   localparam logic [1:0] LD_WAIT = 2'd2;
   localparam logic [1:0] DRAIN   = 2'd3;

   localparam logic [1:0] MEMOP_BYTE = 2'd0;
   localparam logic [1:0] MEMOP_HALF = 2'd1;

   logic [1:0]           state_q, state_d;
   logic [WA_W-1:0]      sb_addr_q [SB_DEPTH];
   logic [WORD_SIZE-1:0] sb_data_q [SB_DEPTH];
   logic [BYTES-1:0]     sb_be_q   [SB_DEPTH];
   logic [PTR_W-1:0]     sb_head_q, sb_tail_q;
   logic [CNT_W-1:0]     sb_cnt_q, sb_cnt_d;

   logic [OFF_W-1:0]     off;
   logic [WA_W-1:0]      word_addr;
   logic [OFF_W+2:0]     shamt;
   logic [BYTES-1:0]     need_be, st_be;
   logic                 misal, is_ld, is_st, is_fence;
   logic                 sb_full, fwd_hit, fwd_cover, ld_fwd, ld_mem, ld_done;
   logic [PTR_W-1:0]     fwd_idx;
   logic                 req, we, deq, enq, stall, retire;
   logic [WORD_SIZE-1:0] addr, wdata;
   logic [BYTES-1:0]     be;
   logic [WORD_SIZE-1:0] ld_raw, ld_sh, ld_ext, res;

   assign off       = alu_res_i[OFF_W-1:0];
   assign word_addr = alu_res_i[WORD_SIZE-1:OFF_W];
   assign shamt     = {off, 3'b000};
   assign sb_full   = (sb_cnt_q == CNT_W'(SB_DEPTH));

   always_comb begin
      misal = 1'b0;
      if (ex_valid_i && (memop_rd_i || memop_wr_i)) begin
         if (memop_type_i == MEMOP_HALF) misal = off[0];
         else if (memop_type_i != MEMOP_BYTE) misal = (off != '0);
      end
   end

   assign is_ld    = ex_valid_i && memop_rd_i && !misal;
   assign is_st    = ex_valid_i && memop_wr_i && !memop_rd_i && !misal;
   assign is_fence = ex_valid_i && fence_i;

   always_comb begin
      case (memop_type_i)
         MEMOP_BYTE: need_be = BYTES'(1) << off;
         MEMOP_HALF: need_be = BYTES'(3) << off;
         default:    need_be = '1;
      endcase
   end
   assign st_be = need_be;

   // Scan oldest to youngest so the last hit is the youngest matching entry.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_idx = '0;
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
         if ((CNT_W'(k) < sb_cnt_q) && (sb_addr_q[sb_head_q + PTR_W'(k)] == word_addr)) begin
            fwd_hit = 1'b1;
            fwd_idx = sb_head_q + PTR_W'(k);
         end
      end
   end

   assign fwd_cover = ((sb_be_q[fwd_idx] & need_be) == need_be);
   assign ld_fwd    = is_ld && fwd_hit && fwd_cover;
   assign ld_mem    = is_ld && !fwd_hit;

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      be      = '0;
      deq     = 1'b0;
      ld_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld_mem) begin
               req     = 1'b1;
               addr    = {word_addr, {OFF_W{1'b0}}};
               be      = need_be;
               state_d = mem_gnt_i ? LD_WAIT : LD_REQ;
            end else if (sb_cnt_q != '0) begin
               req   = 1'b1;
               we    = 1'b1;
               addr  = {sb_addr_q[sb_head_q], {OFF_W{1'b0}}};
               wdata = sb_data_q[sb_head_q];
               be    = sb_be_q[sb_head_q];
               if (mem_gnt_i) deq = 1'b1;
               else           state_d = DRAIN;
            end
         end
         LD_REQ: begin
            req  = 1'b1;
            addr = {word_addr, {OFF_W{1'b0}}};
            be   = need_be;
            if (mem_gnt_i) state_d = LD_WAIT;
         end
         LD_WAIT: begin
            if (mem_rvalid_i) begin
               ld_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            req   = 1'b1;
            we    = 1'b1;
            addr  = {sb_addr_q[sb_head_q], {OFF_W{1'b0}}};
            wdata = sb_data_q[sb_head_q];
            be    = sb_be_q[sb_head_q];
            if (mem_gnt_i) begin
               deq     = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (misal)         stall = 1'b0;
      else if (is_fence) stall = !((sb_cnt_q == '0) && (state_q == IDLE) && !req);
      else if (is_st)    stall = sb_full;
      else if (is_ld)    stall = !(ld_fwd || ld_done);
   end

   assign retire = ex_valid_i && !stall;
   assign enq    = retire && is_st;

   always_comb begin
      case ({enq, deq})
         2'b10:   sb_cnt_d = sb_cnt_q + CNT_W'(1);
         2'b01:   sb_cnt_d = sb_cnt_q - CNT_W'(1);
         default: sb_cnt_d = sb_cnt_q;
      endcase
   end

   assign ld_raw = ld_done ? mem_rdata_i : sb_data_q[fwd_idx];
   assign ld_sh  = ld_raw >> shamt;

   always_comb begin
      case (memop_type_i)
         MEMOP_BYTE: ld_ext = {{(WORD_SIZE-8){memop_sign_ext_i & ld_sh[7]}}, ld_sh[7:0]};
         MEMOP_HALF: ld_ext = {{(WORD_SIZE-16){memop_sign_ext_i & ld_sh[15]}}, ld_sh[15:0]};
         default:    ld_ext = ld_sh;
      endcase
   end
   assign res = is_ld ? ld_ext : alu_res_i;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q   <= IDLE;
         sb_head_q <= '0;
         sb_tail_q <= '0;
         sb_cnt_q  <= '0;
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_addr_q[i] <= '0;
            sb_data_q[i] <= '0;
            sb_be_q[i]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         sb_cnt_q <= sb_cnt_d;
         if (deq) sb_head_q <= sb_head_q + PTR_W'(1);
         if (enq) begin
            sb_addr_q[sb_tail_q] <= word_addr;
            sb_data_q[sb_tail_q] <= rf_st_data_i << shamt;
            sb_be_q[sb_tail_q]   <= st_be;
            sb_tail_q            <= sb_tail_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         wb_valid_o   <= 1'b0;
         op_res_o     <= '0;
         rf_we_o      <= 1'b0;
         rf_waddr_o   <= '0;
         tkbr_o       <= 1'b0;
         new_pc_o     <= '0;
         misaligned_o <= 1'b0;
      end else begin
         wb_valid_o <= retire;
         if (retire) begin
            op_res_o     <= res;
            rf_we_o      <= rf_we_i && !misal;
            rf_waddr_o   <= rf_waddr_i;
            tkbr_o       <= tkbr_i;
            new_pc_o     <= new_pc_i;
            misaligned_o <= misal;
         end
      end
   end

   // Keep the memory port and stall quiet while reset is asserted, even with a load presented.
   assign stall_o     = rsn_i & stall;
   assign mem_req_o   = rsn_i & req;
   assign mem_we_o    = rsn_i & we;
   assign mem_addr_o  = rsn_i ? addr : '0;
   assign mem_wdata_o = rsn_i ? wdata : '0;
   assign mem_be_o    = rsn_i ? be : '0;
   assign sb_empty_o  = (sb_cnt_q == '0);

endmodule

// File: tb/tb_segre_mem_stage_sb.sv
// Directed bench for segre_mem_stage_sb: ALU bypass, forwarding, memory loads, SB full,
// misalignment, fence drain, partial-cover stall and mid-load reset.
module tb_segre_mem_stage_sb;

   logic        clk_i = 1'b0;
   logic        rsn_i;
   logic        ex_valid_i;
   logic [31:0] alu_res_i, rf_st_data_i, new_pc_i, mem_rdata_i;
   logic [1:0]  memop_type_i;
   logic        memop_sign_ext_i, memop_rd_i, memop_wr_i, fence_i, rf_we_i, tkbr_i;
   logic [4:0]  rf_waddr_i;
   logic        mem_gnt_i, mem_rvalid_i;
   logic        stall_o, mem_req_o, mem_we_o, wb_valid_o, rf_we_o, tkbr_o;
   logic        misaligned_o, sb_empty_o;
   logic [31:0] mem_addr_o, mem_wdata_o, op_res_o, new_pc_o;
   logic [3:0]  mem_be_o;
   logic [4:0]  rf_waddr_o;

   int n_vec = 0;
   int n_err = 0;

   segre_mem_stage_sb dut (
      .clk_i(clk_i), .rsn_i(rsn_i), .ex_valid_i(ex_valid_i), .alu_res_i(alu_res_i),
      .rf_st_data_i(rf_st_data_i), .memop_type_i(memop_type_i),
      .memop_sign_ext_i(memop_sign_ext_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
      .fence_i(fence_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .tkbr_i(tkbr_i),
      .new_pc_i(new_pc_i), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .wb_valid_o(wb_valid_o), .op_res_o(op_res_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
      .tkbr_o(tkbr_o), .new_pc_o(new_pc_o), .misaligned_o(misaligned_o), .sb_empty_o(sb_empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic ev, input logic [31:0] alu, input logic [31:0] std,
                        input logic [1:0] ty, input logic sx, input logic rd, input logic wr,
                        input logic fn, input logic we, input logic [4:0] wa);
      ex_valid_i = ev; alu_res_i = alu; rf_st_data_i = std; memop_type_i = ty;
      memop_sign_ext_i = sx; memop_rd_i = rd; memop_wr_i = wr; fence_i = fn;
      rf_we_i = we; rf_waddr_i = wa;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   initial begin
      rsn_i = 1'b0; tkbr_i = 1'b0; new_pc_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      idle();
      #2;
      chk("rst_sb_empty", {31'b0, sb_empty_o}, 32'd1);
      chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
      chk("rst_req", {31'b0, mem_req_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      chk("rst_op_res", op_res_o, 32'h0);
      #10 rsn_i = 1'b1;
      cyc();

      // ALU bypass
      drive(1'b1, 32'h1234, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
      #1 chk("alu_stall", {31'b0, stall_o}, 32'd0);
      cyc();
      chk("alu_wb_valid", {31'b0, wb_valid_o}, 32'd1);
      chk("alu_op_res", op_res_o, 32'h1234);
      chk("alu_waddr", {27'b0, rf_waddr_o}, 32'd5);
      idle();
      cyc();
      chk("idle_wb_valid", {31'b0, wb_valid_o}, 32'd0);

      // SW 0x100 then LB 0x101 forwarded
      drive(1'b1, 32'h100, 32'hAABBCCDD, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      #1 chk("sw_stall", {31'b0, stall_o}, 32'd0);
      cyc();
      chk("sw_sb_nonempty", {31'b0, sb_empty_o}, 32'd0);
      drive(1'b1, 32'h101, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
      #1 chk("fwd_stall", {31'b0, stall_o}, 32'd0);
      chk("fwd_no_read", {31'b0, mem_req_o & ~mem_we_o}, 32'd0);
      chk("fwd_drain_addr", mem_addr_o, 32'h100);
      chk("fwd_drain_wdata", mem_wdata_o, 32'hAABBCCDD);
      cyc();
      chk("fwd_op_res", op_res_o, 32'hFFFFFFCC);
      chk("fwd_wb_valid", {31'b0, wb_valid_o}, 32'd1);
      idle(); mem_gnt_i = 1'b1;
      cyc();
      mem_gnt_i = 1'b0;
      chk("fwd_drained", {31'b0, sb_empty_o}, 32'd1);

      // LHU 0x202 from memory, rvalid three cycles after grant
      drive(1'b1, 32'h202, 32'h0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
      mem_gnt_i = 1'b1;
      #1 chk("ld_req", {31'b0, mem_req_o}, 32'd1);
      chk("ld_we", {31'b0, mem_we_o}, 32'd0);
      chk("ld_addr", mem_addr_o, 32'h200);
      chk("ld_stall0", {31'b0, stall_o}, 32'd1);
      cyc();
      mem_gnt_i = 1'b0;
      #1 chk("ld_stall1", {31'b0, stall_o}, 32'd1);
      chk("ld_wait_no_req", {31'b0, mem_req_o}, 32'd0);
      cyc();
      #1 chk("ld_stall2", {31'b0, stall_o}, 32'd1);
      cyc();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8000F00D;
      #1 chk("ld_rvalid_stall", {31'b0, stall_o}, 32'd0);
      cyc();
      mem_rvalid_i = 1'b0; idle();
      chk("ld_op_res", op_res_o, 32'h00008000);
      chk("ld_wb_valid", {31'b0, wb_valid_o}, 32'd1);

      // Five stores into a 4-entry buffer with grant held low
      drive(1'b1, 32'h003, 32'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h010, 32'h22222222, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      #1 chk("sb_be_addr3", {28'b0, mem_be_o}, 32'h8);
      chk("sb_wdata_addr3", mem_wdata_o, 32'h11000000);
      chk("sb_addr_addr3", mem_addr_o, 32'h0);
      cyc();
      drive(1'b1, 32'h020, 32'h33333333, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h030, 32'h44444444, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h040, 32'h55555555, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      #1 chk("full_stall_a", {31'b0, stall_o}, 32'd1);
      cyc();
      #1 chk("full_stall_b", {31'b0, stall_o}, 32'd1);
      mem_gnt_i = 1'b1;
      #1 chk("full_stall_gnt", {31'b0, stall_o}, 32'd1);
      chk("full_head_addr", mem_addr_o, 32'h0);
      cyc();
      mem_gnt_i = 1'b0;
      #1 chk("full_unstall", {31'b0, stall_o}, 32'd0);
      chk("order_addr1", mem_addr_o, 32'h010);
      cyc();
      idle(); mem_gnt_i = 1'b1;
      #1 chk("order_d1", mem_addr_o, 32'h010);
      cyc();
      #1 chk("order_d2", mem_addr_o, 32'h020);
      cyc();
      #1 chk("order_d3", mem_addr_o, 32'h030);
      cyc();
      #1 chk("order_d4", mem_addr_o, 32'h040);
      cyc();
      mem_gnt_i = 1'b0;
      chk("order_empty", {31'b0, sb_empty_o}, 32'd1);

      // Misaligned SH
      drive(1'b1, 32'h301, 32'hBEEF, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9);
      #1 chk("mis_stall", {31'b0, stall_o}, 32'd0);
      chk("mis_req", {31'b0, mem_req_o}, 32'd0);
      cyc();
      idle();
      chk("mis_flag", {31'b0, misaligned_o}, 32'd1);
      chk("mis_rf_we", {31'b0, rf_we_o}, 32'd0);
      chk("mis_no_enq", {31'b0, sb_empty_o}, 32'd1);

      // Fence with two buffered stores
      drive(1'b1, 32'h500, 32'hA5A5A5A5, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h504, 32'h5A5A5A5A, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
      #1 chk("fence_stall0", {31'b0, stall_o}, 32'd1);
      cyc();
      mem_gnt_i = 1'b1;
      #1 chk("fence_stall1", {31'b0, stall_o}, 32'd1);
      chk("fence_head0", mem_addr_o, 32'h500);
      cyc();
      #1 chk("fence_stall2", {31'b0, stall_o}, 32'd1);
      chk("fence_head1", mem_addr_o, 32'h504);
      cyc();
      mem_gnt_i = 1'b0;
      #1 chk("fence_go", {31'b0, stall_o}, 32'd0);
      cyc();
      idle();
      chk("fence_retired", {31'b0, wb_valid_o}, 32'd1);
      chk("fence_not_mis", {31'b0, misaligned_o}, 32'd0);

      // SB 0x400 then LW 0x400: partial cover waits for drain, then reads memory
      drive(1'b1, 32'h400, 32'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      cyc();
      drive(1'b1, 32'h400, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4);
      #1 chk("part_stall0", {31'b0, stall_o}, 32'd1);
      chk("part_drain_we", {31'b0, mem_we_o}, 32'd1);
      cyc();
      mem_gnt_i = 1'b1;
      #1 chk("part_stall1", {31'b0, stall_o}, 32'd1);
      chk("part_drain_we1", {31'b0, mem_we_o}, 32'd1);
      cyc();
      #1 chk("part_rd_req", {31'b0, mem_req_o & ~mem_we_o}, 32'd1);
      chk("part_rd_addr", mem_addr_o, 32'h400);
      chk("part_stall2", {31'b0, stall_o}, 32'd1);
      cyc();
      mem_gnt_i = 1'b0;
      #1 chk("part_wait_stall", {31'b0, stall_o}, 32'd1);

      // Reset while waiting for load data
      rsn_i = 1'b0;
      #1 chk("mrst_stall", {31'b0, stall_o}, 32'd0);
      chk("mrst_req", {31'b0, mem_req_o}, 32'd0);
      chk("mrst_addr", mem_addr_o, 32'h0);
      chk("mrst_wb_valid", {31'b0, wb_valid_o}, 32'd0);
      chk("mrst_op_res", op_res_o, 32'h0);
      chk("mrst_sb_empty", {31'b0, sb_empty_o}, 32'd1);
      idle();
      #2 rsn_i = 1'b1;
      cyc();
      drive(1'b1, 32'hBEEF, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
      #1 chk("post_rst_stall", {31'b0, stall_o}, 32'd0);
      cyc();
      idle();
      chk("post_rst_op_res", op_res_o, 32'hBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
